// File: rtl/code_lock_fsm_pkg.sv
// Shared encodings and helpers for the keypad code-lock controller.
package code_lock_fsm_pkg;

    typedef enum logic [1:0] {
        S_WPR  = 2'd0,
        S_CHK  = 2'd1,
        S_OPEN = 2'd2,
        S_BLK  = 2'd3
    } state_t;

    localparam logic SL_LOCKED = 1'b1;
    localparam logic SL_OPEN   = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/code_lock_fsm_lock_timer.sv
// Loadable down-counter shared by the open window and the lockout period.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Saturates at zero so a late decrement can never wrap the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Keypad code-lock controller: digit entry, compare, timed open window and lockout.
// Build option CODE_LOCK_KEY_EDGE_EN: accept digits on rising edges of a level key_valid.
module code_lock_fsm
    import code_lock_fsm_pkg::*;
#(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter int MAX_TRIES      = 3,
    parameter int OPEN_CYCLES    = 1000,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_code,
    input  logic                          key_clr,
    input  logic [CODE_LEN*DIGIT_W-1:0]   code_ref,
    output logic [1:0]                    st,
    output logic                          st_l,
    output logic                          alarm,
    output logic [$clog2(CODE_LEN+1)-1:0] digit_cnt,
    output logic [3:0]                    tries_left
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int TIMER_W = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);

    state_t              state;
    logic [CODE_W-1:0]   entry;
    logic                accept;
    logic [DIGIT_W-1:0]  digit;
    logic                match;
    logic                tmr_load;
    logic                tmr_dec;
    logic                tmr_zero;
    logic [TIMER_W-1:0]  tmr_val;

`ifdef CODE_LOCK_KEY_EDGE_EN
    logic               key_q;
    logic               key_q2;
    logic [DIGIT_W-1:0] code_q;

    // Code travels with the registered strobe so digit and edge stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= 1'b0;
            key_q2 <= 1'b0;
            code_q <= '0;
        end else begin
            key_q  <= key_valid;
            key_q2 <= key_q;
            code_q <= key_code;
        end
    end

    assign accept = key_q & ~key_q2;
    assign digit  = code_q;
`else
    assign accept = key_valid;
    assign digit  = key_code;
`endif

    assign match    = (entry == code_ref);
    assign tmr_load = (state == S_CHK) && (match || (tries_left == 4'd1));
    assign tmr_val  = match ? TIMER_W'(OPEN_CYCLES - 1) : TIMER_W'(LOCKOUT_CYCLES - 1);
    assign tmr_dec  = (state == S_OPEN) || (state == S_BLK);

    lock_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_WPR;
            st_l       <= SL_LOCKED;
            alarm      <= 1'b0;
            digit_cnt  <= '0;
            tries_left <= 4'(MAX_TRIES);
            entry      <= '0;
        end else begin
            unique case (state)
                S_WPR: begin
                    if (key_clr) begin
                        entry     <= '0;
                        digit_cnt <= '0;
                    end else if (accept) begin
                        entry     <= (entry << DIGIT_W) | CODE_W'(digit);
                        digit_cnt <= digit_cnt + 1'b1;
                        if (digit_cnt == CNT_W'(CODE_LEN - 1)) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    digit_cnt <= '0;
                    entry     <= '0;
                    if (match) begin
                        state      <= S_OPEN;
                        st_l       <= SL_OPEN;
                        tries_left <= 4'(MAX_TRIES);
                    end else if (tries_left > 4'd1) begin
                        state      <= S_WPR;
                        tries_left <= tries_left - 4'd1;
                    end else begin
                        state      <= S_BLK;
                        tries_left <= 4'd0;
                        alarm      <= 1'b1;
                    end
                end
                S_OPEN: begin
                    if (key_clr || tmr_zero) begin
                        state <= S_WPR;
                        st_l  <= SL_LOCKED;
                    end
                end
                S_BLK: begin
                    if (tmr_zero) begin
                        state      <= S_WPR;
                        alarm      <= 1'b0;
                        tries_left <= 4'(MAX_TRIES);
                    end
                end
                default: state <= S_WPR;
            endcase
        end
    end

    assign st = state;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Randomized and directed bench for code_lock_fsm against a cycle-count reference model.
module tb_code_lock_fsm;

    localparam int DIGIT_W  = 4;
    localparam int CODE_LEN = 4;
    localparam int MAX_T    = 3;
    localparam int OPEN_C   = 8;
    localparam int LOCK_C   = 16;
    localparam int CODE     = 'h1234;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_clr = 1'b0;
    logic [15:0] code_ref = 16'h1234;
    logic [1:0]  st;
    logic        st_l;
    logic        alarm;
    logic [2:0]  digit_cnt;
    logic [3:0]  tries_left;

    int total = 0;
    int bad   = 0;

    // Reference model: mode, entered digits, failure count, cycles remaining.
    int m_mode;      // 0 wait, 1 check, 2 open, 3 blocked
    int m_digits[$];
    int m_fail;
    int m_left;
    bit m_kv1, m_kv2;
    int m_kc1;

    code_lock_fsm #(
        .DIGIT_W        (DIGIT_W),
        .CODE_LEN       (CODE_LEN),
        .MAX_TRIES      (MAX_T),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_clr    (key_clr),
        .code_ref   (code_ref),
        .st         (st),
        .st_l       (st_l),
        .alarm      (alarm),
        .digit_cnt  (digit_cnt),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_digits.delete();
        m_fail = 0;
        m_left = 0;
        m_kv1 = 0;
        m_kv2 = 0;
        m_kc1 = 0;
    endtask

    task automatic model_edge(input bit kv, input int kc, input bit clr);
        bit acc;
        int dig;
        int val;
`ifdef CODE_LOCK_KEY_EDGE_EN
        acc = m_kv1 && !m_kv2;
        dig = m_kc1;
        m_kv2 = m_kv1;
        m_kv1 = kv;
        m_kc1 = kc;
`else
        acc = kv;
        dig = kc;
`endif
        case (m_mode)
            0: begin
                if (clr) m_digits.delete();
                else if (acc) begin
                    m_digits.push_back(dig);
                    if (m_digits.size() == CODE_LEN) m_mode = 1;
                end
            end
            1: begin
                val = 0;
                foreach (m_digits[i]) val = val * (1 << DIGIT_W) + m_digits[i];
                m_digits.delete();
                if (val == CODE) begin
                    m_mode = 2; m_fail = 0; m_left = OPEN_C;
                end else begin
                    m_fail++;
                    if (m_fail == MAX_T) begin
                        m_mode = 3; m_left = LOCK_C;
                    end else m_mode = 0;
                end
            end
            2: begin
                m_left--;
                if (clr || m_left == 0) m_mode = 0;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0; m_fail = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("st", int'(st), m_mode);
        check_val("st_l", int'(st_l), (m_mode == 2) ? 0 : 1);
        check_val("alarm", int'(alarm), (m_mode == 3) ? 1 : 0);
        check_val("digit_cnt", int'(digit_cnt), m_digits.size());
        check_val("tries_left", int'(tries_left), MAX_T - m_fail);
    endtask

    task automatic step(input bit kv, input int kc, input bit clr);
        key_valid = kv;
        key_code  = 4'(kc);
        key_clr   = clr;
        @(posedge clk);
        model_edge(kv, kc, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input int d);
        step(1, d, 0);
        step(0, d, 0);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Asserts reset between edges so outputs are checked before any clock edge.
    task automatic do_reset();
        key_valid = 0; key_clr = 0; key_code = 0;
        #2 rst = 1'b0;
        #1;
        check_val("rst_st", int'(st), 0);
        check_val("rst_st_l", int'(st_l), 1);
        check_val("rst_alarm", int'(alarm), 0);
        check_val("rst_cnt", int'(digit_cnt), 0);
        check_val("rst_tries", int'(tries_left), MAX_T);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Correct code: check, open window, relock.
        press(1); press(2); press(3);
        step(1, 4, 0);
`ifndef CODE_LOCK_KEY_EDGE_EN
        check_val("chk_after_last", int'(st), 1);
        step(0, 0, 0);
        check_val("open_lock_out", int'(st_l), 0);
`endif
        idle(12);

        // Three wrong codes into lockout; keys pressed while blocked.
        for (int t = 0; t < 3; t++) begin
            enter(1, 2, 3, 5);
            idle(2);
        end
        for (int i = 0; i < 8; i++) press(i % 5);
        idle(4);

        // Clear with simultaneous key, then correct entry.
        press(1); press(2);
        step(1, 3, 1);
        step(0, 0, 1);
        enter(1, 2, 3, 4);
        idle(4);
        step(0, 0, 1);
        idle(2);

        // Early relock during the open window.
        enter(1, 2, 3, 4);
        idle(3);
        step(0, 0, 1);
        idle(2);

        // Reset during lockout and during the open window.
        for (int t = 0; t < 3; t++) enter(9, 9, 9, 9);
        idle(3);
        do_reset();
        enter(1, 2, 3, 4);
        idle(3);
        do_reset();
        enter(1, 2, 3, 4);
        idle(12);

        // Held key for five cycles.
        for (int i = 0; i < 5; i++) step(1, 1, 0);
        idle(3);
        step(0, 0, 1);
        idle(2);

        // Random traffic biased toward the correct next digit.
        for (int i = 0; i < 3000; i++) begin
            bit kv, clr;
            int kc;
            kv  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 39) == 0);
            kc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : ((m_digits.size() % CODE_LEN) + 1);
            step(kv, kc, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
